// File: rtl/bundle_stream_ctrl.sv
// rtl/bundle_stream_ctrl.sv - sequencer for the bundling counter bank and the 256-bit sign-vector stream
// Gates core results into the counters, waits out the sign pipeline, then streams NSEG beats.
module bundle_stream_ctrl #(
  parameter int CORENUM  = 14,
  parameter int NSEG     = 4,
  parameter int PIPE_LAT = 3,
  parameter int CW       = 27
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CORENUM-1:0]        core_valid,
  input  logic                      core_last,
  input  logic                      dst_ready,
  output logic [CORENUM-1:0]        store,
  output logic                      store_flag,
  output logic                      stream_v,
  output logic [$clog2(NSEG)-1:0]   stream_i,
  output logic                      dst_valid,
  output logic                      dst_last,
  output logic                      busy,
  output logic                      done,
  output logic [CW-1:0]             acc_cnt
);

  localparam int IW = $clog2(NSEG);
  localparam int DW = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [IW:0]   SEG_END   = (IW + 1)'(NSEG);
  localparam logic [IW:0]   LAST_SEG  = (IW + 1)'(NSEG - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CORENUM-1:0] store_q, store_d;
  logic              store_flag_q, store_flag_d;
  logic              first_q, first_d;
  logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [IW:0]       issue_idx_q, issue_idx_d;
  logic              dst_valid_q, dst_valid_d;
  logic              dst_last_q, dst_last_d;

  logic issue;
  logic consume;
  logic drain_done;

  // A new segment may be captured whenever the output slot is empty or emptying this cycle.
  assign issue      = (state_q == STREAM) && (issue_idx_q < SEG_END) && (!dst_valid_q || dst_ready);
  assign consume    = dst_valid_q && dst_ready;
  assign drain_done = (state_q == DRAIN) && (drain_cnt_q == DRAIN_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= '0;
      store_flag_q <= 1'b0;
      first_q      <= 1'b0;
      acc_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      issue_idx_q  <= '0;
      dst_valid_q  <= 1'b0;
      dst_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      store_flag_q <= store_flag_d;
      first_q      <= first_d;
      acc_cnt_q    <= acc_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      issue_idx_q  <= issue_idx_d;
      dst_valid_q  <= dst_valid_d;
      dst_last_q   <= dst_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (core_last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = STREAM;
      STREAM:  if (consume && dst_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    store_d      = '0;
    store_flag_d = 1'b0;
    first_d      = first_q;
    acc_cnt_d    = acc_cnt_q;
    drain_cnt_d  = '0;
    issue_idx_d  = issue_idx_q;
    dst_valid_d  = dst_valid_q;
    dst_last_d   = dst_last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          first_d     = 1'b1;
          acc_cnt_d   = '0;
          issue_idx_d = '0;
        end
      end
      ACCUM: begin
        store_d = core_valid;
        // The first nonzero store tells the counters to load rather than accumulate.
        if (|core_valid) begin
          store_flag_d = first_q;
          first_d      = 1'b0;
          if (acc_cnt_q != {CW{1'b1}}) acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_done ? '0 : drain_cnt_q + 1'b1;
        issue_idx_d = '0;
      end
      STREAM: begin
        if (issue) begin
          issue_idx_d = issue_idx_q + 1'b1;
          dst_valid_d = 1'b1;
          dst_last_d  = (issue_idx_q == LAST_SEG);
        end else if (consume) begin
          dst_valid_d = 1'b0;
          dst_last_d  = 1'b0;
        end
      end
      DONE: begin
        dst_valid_d = 1'b0;
        dst_last_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    store      = store_q;
    store_flag = store_flag_q;
    stream_v   = issue;
    stream_i   = issue_idx_q[IW-1:0];
    dst_valid  = dst_valid_q;
    dst_last   = dst_last_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    acc_cnt    = acc_cnt_q;
  end

endmodule

// File: tb/tb_bundle_stream_ctrl.sv
// tb/tb_bundle_stream_ctrl.sv - randomized self-checking bench for bundle_stream_ctrl
module tb_bundle_stream_ctrl;

  localparam int CORENUM  = 14;
  localparam int NSEG     = 4;
  localparam int PIPE_LAT = 3;
  localparam int CW       = 27;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CORENUM-1:0] core_valid;
  logic               core_last;
  logic               dst_ready;
  logic [CORENUM-1:0] store;
  logic               store_flag;
  logic               stream_v;
  logic [1:0]         stream_i;
  logic               dst_valid;
  logic               dst_last;
  logic               busy;
  logic               done;
  logic [CW-1:0]      acc_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CORENUM-1:0] acc_pat[$];

  always #5 clk = ~clk;

  bundle_stream_ctrl #(
    .CORENUM(CORENUM), .NSEG(NSEG), .PIPE_LAT(PIPE_LAT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .core_valid(core_valid),
    .core_last(core_last), .dst_ready(dst_ready), .store(store),
    .store_flag(store_flag), .stream_v(stream_v), .stream_i(stream_i),
    .dst_valid(dst_valid), .dst_last(dst_last), .busy(busy), .done(done),
    .acc_cnt(acc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int exp_acc);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_store"}, 32'(store), 32'd0);
    chk({tag, "_flag"}, 32'(store_flag), 32'd0);
    chk({tag, "_stream_v"}, 32'(stream_v), 32'd0);
    chk({tag, "_dst_valid"}, 32'(dst_valid), 32'd0);
    chk({tag, "_dst_last"}, 32'(dst_last), 32'd0);
    chk({tag, "_acc_cnt"}, 32'(acc_cnt), 32'(exp_acc));
  endtask

  // One bundling run: accumulate the cycles in acc_pat, then a core_last cycle carrying last_cv.
  task automatic run(input logic [CORENUM-1:0] last_cv, input int ready_pct, input bit stray,
                     input bit stall5, input int rst_after);
    logic [CORENUM-1:0] prev_cv;
    logic [CORENUM-1:0] cv;
    bit seen_nz, lst, r, exp_sv, slot_v, slot_last, rst_pend, finished;
    int exp_acc, issue, hs, stall_left;

    @(posedge clk); #1;
    start = 1'b1; core_valid = '0; core_last = 1'b0; dst_ready = 1'b0; #1;
    chk("start_busy", 32'(busy), 32'd0);

    prev_cv = '0; seen_nz = 0; exp_acc = 0;
    for (int i = 0; i <= acc_pat.size(); i++) begin
      lst = (i == acc_pat.size());
      cv  = lst ? last_cv : acc_pat[i];
      @(posedge clk); #1;
      start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      core_valid = cv; core_last = lst; dst_ready = 1'($urandom_range(0, 1)); #1;
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_store", 32'(store), 32'(prev_cv));
      chk("acc_flag", 32'(store_flag), 32'((prev_cv != 0) && !seen_nz));
      chk("acc_cnt_run", 32'(acc_cnt), 32'(exp_acc));
      chk("acc_stream_v", 32'(stream_v), 32'd0);
      chk("acc_dst_valid", 32'(dst_valid), 32'd0);
      chk("acc_done", 32'(done), 32'd0);
      if (prev_cv != 0) seen_nz = 1;
      if (cv != 0) exp_acc++;
      prev_cv = cv;
    end

    issue = 0; hs = 0; slot_v = 0; slot_last = 0; rst_pend = 0; finished = 0;
    stall_left = stall5 ? 5 : 0;
    for (int d = 0; d < 300; d++) begin
      @(posedge clk); #1;
      r = ($urandom_range(0, 99) < ready_pct);
      if (issue == 1 && stall_left > 0) begin
        r = 0;
        stall_left--;
      end
      start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      core_valid = CORENUM'($urandom); core_last = 1'($urandom_range(0, 1));
      dst_ready = r;
      if (rst_pend) rst = 1'b1;
      #1;
      chk("run_busy", 32'(busy), 32'd1);
      chk("drain_store", 32'(store), d == 0 ? 32'(prev_cv) : 32'd0);
      chk("drain_flag", 32'(store_flag), 32'(d == 0 && prev_cv != 0 && !seen_nz));
      exp_sv = (d >= PIPE_LAT + 1) && (issue < NSEG) && (!slot_v || r);
      chk("stream_v", 32'(stream_v), 32'(exp_sv));
      if (exp_sv) chk("stream_i", 32'(stream_i), 32'(issue));
      chk("dst_valid", 32'(dst_valid), 32'(slot_v));
      chk("dst_last", 32'(dst_last), 32'(slot_v && slot_last));
      chk("done", 32'(done), 32'(hs == NSEG));
      if (rst_pend) begin
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; core_valid = '0; core_last = 1'b0; #1;
        check_idle("post_rst", 0);
        return;
      end
      if (hs == NSEG) begin
        finished = 1;
        break;
      end
      if (slot_v && r) hs++;
      if (exp_sv) begin
        slot_v = 1; slot_last = (issue == NSEG - 1); issue++;
      end else if (slot_v && r) begin
        slot_v = 0; slot_last = 0;
      end
      if (rst_after >= 0 && hs == rst_after) rst_pend = 1;
    end
    chk("run_timeout", 32'(finished), 32'd1);

    @(posedge clk); #1;
    start = 1'b0; core_valid = '0; core_last = 1'b0; #1;
    check_idle("end", exp_acc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; core_valid = '0; core_last = 1'b0; dst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_idle("reset", 0);
    @(posedge clk); #1;
    rst = 1'b0;

    acc_pat = '{14'h3FFF, 14'h3FFF, 14'h3FFF};
    run(14'h0000, 100, 0, 0, -1);

    acc_pat = '{14'h1555, 14'h0AAA};
    run(14'h0000, 100, 0, 1, -1);

    acc_pat = '{14'h0001, 14'h0000, 14'h2000};
    run(14'h0000, 100, 0, 0, -1);

    acc_pat = '{};
    run(14'h0000, 100, 0, 0, -1);

    acc_pat = '{14'h0F0F, 14'h0000};
    run(14'h0003, 100, 0, 0, 2);
    acc_pat = '{14'h0100};
    run(14'h0000, 100, 0, 0, -1);

    acc_pat = '{14'h0000, 14'h00F0, 14'h0000};
    run(14'h0001, 60, 1, 0, -1);

    for (int k = 0; k < 20; k++) begin
      acc_pat = '{};
      for (int j = 0; j < int'($urandom_range(0, 8)); j++)
        acc_pat.push_back(($urandom_range(0, 2) == 0) ? 14'h0000 : CORENUM'($urandom));
      run(($urandom_range(0, 1) == 0) ? 14'h0000 : CORENUM'($urandom),
          int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), 1'b0,
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
